// File: rtl/fcp_pkg.sv
// Shared definitions for the FCP CRC-8 path (RX checker and TX generator).
package fcp_pkg;

  localparam logic [7:0] CRC8_POLY = 8'h39;
  localparam logic [7:0] CRC8_INIT = 8'h00;

  localparam int ERR_CRC = 0;
  localparam int ERR_OVF = 1;
  localparam int ERR_LEN = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    REPORT = 2'd2
  } state_t;

endpackage

// File: rtl/fcp_crc_chk_if.sv
// Byte stream from the FCP deserializer and the per-frame check result.
interface fcp_crc_chk_if #(
  parameter int LEN_W = 5
) ();

  logic             rx_vld;
  logic [7:0]       rx_byte;
  logic             rx_sof;
  logic             rx_eof;
  logic             rx_abort;
  logic             busy;
  logic             chk_done;
  logic             chk_ok;
  logic [2:0]       chk_err;
  logic [LEN_W-1:0] chk_len;
  logic [7:0]       crc_calc;

  modport master (
    output rx_vld, rx_byte, rx_sof, rx_eof, rx_abort,
    input  busy, chk_done, chk_ok, chk_err, chk_len, crc_calc
  );

  modport slave (
    input  rx_vld, rx_byte, rx_sof, rx_eof, rx_abort,
    output busy, chk_done, chk_ok, chk_err, chk_len, crc_calc
  );

endinterface

// File: rtl/fcp_crc8_upd.sv
// Combinational one-byte CRC-8 step, MSB first, no reflection.
module fcp_crc8_upd
  import fcp_pkg::*;
(
  input  logic [7:0] crc_in,
  input  logic [7:0] data_byte,
  output logic [7:0] crc_out
);

  logic [7:0] crc_v;

  always_comb begin
    crc_v = crc_in ^ data_byte;
    for (int i = 0; i < 8; i++) begin
      crc_v = crc_v[7] ? ((crc_v << 1) ^ CRC8_POLY) : (crc_v << 1);
    end
    crc_out = crc_v;
  end

endmodule

// File: rtl/fcp_crc_chk.sv
// Receive-side FCP CRC-8 checker: accumulates CRC over a frame and validates
// the trailing CRC byte, reporting one result per frame.
module fcp_crc_chk
  import fcp_pkg::*;
#(
  parameter int MAX_BYTES = 16,
  parameter int MIN_BYTES = 1,
  parameter int LEN_W     = 5
) (
  input logic          clk,
  input logic          rst_n,
  fcp_crc_chk_if.slave rx
);

  // cnt includes the CRC byte, so it stops one above MAX_BYTES+1 so that the
  // reported payload length saturates at MAX_BYTES+1.
  localparam int               CNT_W   = LEN_W + 1;
  localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(MAX_BYTES + 2);

  state_t           state, state_nxt;
  logic [7:0]       crc, crc_nxt, crc_prev, prev_nxt;
  logic [7:0]       upd_in, upd_out;
  logic [CNT_W-1:0] cnt, cnt_nxt, payload;
  logic             start, report;
  logic [2:0]       err_now, err_q;
  logic             ok_q;
  logic [LEN_W-1:0] len_q;
  logic [7:0]       calc_q;

  assign start  = rx.rx_vld & rx.rx_sof & ~rx.rx_abort;
  assign upd_in = start ? CRC8_INIT : crc;

  fcp_crc8_upd u_upd (
    .crc_in    (upd_in),
    .data_byte (rx.rx_byte),
    .crc_out   (upd_out)
  );

  always_comb begin
    state_nxt = state;
    crc_nxt   = crc;
    prev_nxt  = crc_prev;
    cnt_nxt   = cnt;
    case (state)
      IDLE, REPORT: begin
        state_nxt = IDLE;
        if (start) begin
          crc_nxt   = upd_out;
          prev_nxt  = CRC8_INIT;
          cnt_nxt   = CNT_W'(1);
          state_nxt = rx.rx_eof ? REPORT : DATA;
        end
      end
      DATA: begin
        if (rx.rx_abort) begin
          state_nxt = IDLE;
        end else if (start) begin
          crc_nxt   = upd_out;
          prev_nxt  = CRC8_INIT;
          cnt_nxt   = CNT_W'(1);
          state_nxt = rx.rx_eof ? REPORT : DATA;
        end else if (rx.rx_vld) begin
          if (cnt != CNT_SAT) begin
            prev_nxt = crc;
            crc_nxt  = upd_out;
            cnt_nxt  = cnt + CNT_W'(1);
          end
          if (rx.rx_eof) begin
            state_nxt = REPORT;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign report  = (state == REPORT);
  assign payload = cnt - CNT_W'(1);

  always_comb begin
    err_now          = 3'b000;
    err_now[ERR_CRC] = (crc != 8'h00);
    err_now[ERR_OVF] = (payload > CNT_W'(MAX_BYTES));
    err_now[ERR_LEN] = (payload < CNT_W'(MIN_BYTES));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      crc      <= CRC8_INIT;
      crc_prev <= CRC8_INIT;
      cnt      <= '0;
      ok_q     <= 1'b0;
      err_q    <= 3'b000;
      len_q    <= '0;
      calc_q   <= 8'h00;
    end else begin
      state    <= state_nxt;
      crc      <= crc_nxt;
      crc_prev <= prev_nxt;
      cnt      <= cnt_nxt;
      if (report) begin
        ok_q   <= (err_now == 3'b000);
        err_q  <= err_now;
        len_q  <= LEN_W'(payload);
        calc_q <= crc_prev;
      end
    end
  end

  // The result is live during REPORT and held from the registers afterwards.
  assign rx.busy     = (state == DATA);
  assign rx.chk_done = report;
  assign rx.chk_ok   = report ? (err_now == 3'b000) : ok_q;
  assign rx.chk_err  = report ? err_now : err_q;
  assign rx.chk_len  = report ? LEN_W'(payload) : len_q;
  assign rx.crc_calc = report ? crc_prev : calc_q;

endmodule

// File: tb/tb_fcp_crc_chk.sv
// Self-checking bench for fcp_crc_chk: frames are modelled on the way in and
// their results are compared when chk_done fires.
module tb_fcp_crc_chk;
  import fcp_pkg::*;

  typedef struct packed {
    logic       ok;
    logic [2:0] err;
    logic [2:0] mask;
    logic [4:0] len;
    logic [7:0] calc;
    logic       calc_chk;
    int         cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_done   = 0;
  int   n_exp    = 0;
  int   cyc      = 0;
  exp_t exp_q[$];
  logic [7:0] pl [0:31];
  logic       last_ok;
  logic [2:0] last_err;
  logic [4:0] last_len;
  logic [7:0] last_calc;

  fcp_crc_chk_if #(.LEN_W(5)) bus ();

  fcp_crc_chk #(
    .MAX_BYTES (16),
    .MIN_BYTES (1),
    .LEN_W     (5)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .rx    (bus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Bit-serial reference CRC, deliberately written differently from the RTL.
  function automatic logic [7:0] crcModel(input logic [7:0] c, input logic [7:0] d);
    logic [7:0] r;
    logic       fb;
    r = c;
    for (int i = 7; i >= 0; i--) begin
      fb = r[7] ^ d[i];
      r  = {r[6:0], 1'b0} ^ (fb ? CRC8_POLY : 8'h00);
    end
    return r;
  endfunction

  task automatic applyStimulus(input logic vld, input logic [7:0] b, input logic sof,
                               input logic eof, input logic abort);
    @(negedge clk);
    bus.rx_vld   = vld;
    bus.rx_byte  = b;
    bus.rx_sof   = sof;
    bus.rx_eof   = eof;
    bus.rx_abort = abort;
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  // Sends pl[0..n-1] then the CRC byte (xor corrupt); n=0 is a lone sof+eof byte.
  task automatic sendFrame(input int n, input int gap, input logic [7:0] corrupt);
    exp_t       e;
    logic [7:0] c;
    logic [7:0] cb;
    logic [7:0] fin;
    c = 8'h00;
    for (int i = 0; i < n; i++) c = crcModel(c, pl[i]);
    cb         = c ^ corrupt;
    fin        = crcModel(c, cb);
    e.len      = (n > 17) ? 5'd17 : 5'(n);
    e.err      = {(n < 1), (n > 16), (fin != 8'h00)};
    e.mask     = (n > 16) ? 3'b110 : 3'b111;
    e.ok       = ((e.err & e.mask) == 3'b000);
    e.calc     = c;
    e.calc_chk = (n <= 16);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b1, pl[i], (i == 0), 1'b0, 1'b0);
      if (gap > 0) idle(gap);
    end
    applyStimulus(1'b1, cb, (n == 0), 1'b1, 1'b0);
    e.cyc = cyc + 1;
    exp_q.push_back(e);
    n_exp++;
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_busy"}, bus.busy, 0);
    checkOutput({tag, "_done"}, bus.chk_done, 0);
    checkOutput({tag, "_ok"}, bus.chk_ok, 0);
    checkOutput({tag, "_err"}, bus.chk_err, 0);
    checkOutput({tag, "_len"}, bus.chk_len, 0);
    checkOutput({tag, "_calc"}, bus.crc_calc, 0);
  endtask

  // Result monitor: samples just after each rising edge.
  always @(posedge clk) begin
    exp_t e;
    cyc++;
    #1;
    if (rst_n && bus.chk_done) begin
      n_done++;
      last_ok   = bus.chk_ok;
      last_err  = bus.chk_err;
      last_len  = bus.chk_len;
      last_calc = bus.crc_calc;
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_done", 1, 0);
      end else begin
        e = exp_q.pop_front();
        checkOutput("latency", cyc, e.cyc);
        checkOutput("chk_ok", bus.chk_ok, e.ok);
        checkOutput("chk_err", bus.chk_err & e.mask, e.err & e.mask);
        checkOutput("chk_len", bus.chk_len, e.len);
        if (e.calc_chk) checkOutput("crc_calc", bus.crc_calc, e.calc);
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst_n        = 1'b0;
    bus.rx_vld   = 1'b0;
    bus.rx_byte  = 8'h00;
    bus.rx_sof   = 1'b0;
    bus.rx_eof   = 1'b0;
    bus.rx_abort = 1'b0;
    idle(3);
    checkReset("rst0");
    rst_n = 1'b1;

    pl[0] = 8'h01;
    sendFrame(1, 0, 8'h00);
    idle(3);
    checkOutput("t1_calc", last_calc, 8'h39);
    checkOutput("t1_ok", last_ok, 1);
    checkOutput("t1_len", last_len, 1);

    pl[0] = 8'h01;
    pl[1] = 8'h00;
    sendFrame(2, 0, 8'h00);
    idle(3);
    checkOutput("t2_calc", last_calc, 8'h9C);
    sendFrame(2, 5, 8'h00);
    idle(3);
    checkOutput("t2_gap_calc", last_calc, 8'h9C);
    checkOutput("t2_gap_len", last_len, 2);

    pl[0] = 8'h01;
    sendFrame(1, 0, 8'h01);
    idle(3);
    checkOutput("t3_err", last_err, 3'b001);
    checkOutput("t3_calc", last_calc, 8'h39);
    sendFrame(0, 0, 8'h00);
    idle(3);
    checkOutput("t3_zero_err", last_err, 3'b100);
    checkOutput("t3_zero_len", last_len, 0);

    for (int i = 0; i < 32; i++) pl[i] = 8'($urandom);
    sendFrame(16, 0, 8'h00);
    sendFrame(17, 0, 8'h00);
    sendFrame(18, 0, 8'h00);
    idle(3);
    checkOutput("ovf_len", last_len, 17);
    checkOutput("ovf_bit", last_err[ERR_OVF], 1);

    applyStimulus(1'b1, 8'h10, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h20, 1'b0, 1'b0, 1'b0);
    checkOutput("mid_busy", bus.busy, 1);
    applyStimulus(1'b1, 8'h33, 1'b0, 1'b1, 1'b1);
    idle(1);
    checkOutput("abort_busy", bus.busy, 0);
    idle(3);

    applyStimulus(1'b1, 8'hAA, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h55, 1'b0, 1'b0, 1'b0);
    pl[0] = 8'h01;
    sendFrame(1, 0, 8'h00);
    idle(3);
    checkOutput("restart_ok", last_ok, 1);

    applyStimulus(1'b1, 8'h12, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h34, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    idle(2);
    checkReset("rst_mid");
    rst_n = 1'b1;
    applyStimulus(1'b1, 8'h39, 1'b0, 1'b1, 1'b0);
    idle(3);

    for (int k = 0; k < 4; k++) begin
      int n;
      n = $urandom_range(1, 8);
      for (int i = 0; i < n; i++) pl[i] = 8'($urandom);
      sendFrame(n, 0, (k == 2) ? 8'h80 : 8'h00);
    end
    idle(4);

    checkOutput("done_count", n_done, n_exp);
    checkOutput("queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
